// File: rtl/pla_io_pkg.sv
// Shared definitions for the PLA vector driver: default bus widths,
// error counter width, settle counter width and the controller state type.
package pla_io_pkg;

    localparam int NUM_IN_DEF  = 22;
    localparam int NUM_OUT_DEF = 29;
    localparam int ERR_W       = 16;
    localparam int CNT_W       = 8;   // holds SETTLE_CYCLES-1 for 1..255

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/pla_vec_cmp.sv
// Masked compare of a captured PLA response against its expected value.
// A bit participates only where mask is 1.
module pla_vec_cmp #(
    parameter int W = 29
) (
    input  logic [W-1:0] z,
    input  logic [W-1:0] exp,
    input  logic [W-1:0] mask,
    output logic         mismatch
);

    // any checked bit that differs flags the whole vector
    assign mismatch = |((z ^ exp) & mask);

endmodule

// File: rtl/pla_vector_driver.sv
// Drives one input cube into an external combinational PLA, waits a fixed
// number of settle cycles, captures the response, compares it under a mask
// and holds the result until the consumer takes it. Mismatches are counted
// in a saturating counter.
module pla_vector_driver
    import pla_io_pkg::*;
#(
    parameter int NUM_IN        = NUM_IN_DEF,
    parameter int NUM_OUT       = NUM_OUT_DEF,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  in_vec,
    input  logic [NUM_OUT-1:0] in_exp,
    input  logic [NUM_OUT-1:0] in_mask,
    output logic [NUM_IN-1:0]  pla_x,
    input  logic [NUM_OUT-1:0] pla_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_z,
    output logic               out_mismatch,
    output logic [ERR_W-1:0]   err_count,
    input  logic               clr_count,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_IN-1:0]  x_q, x_d;
    logic [NUM_OUT-1:0] exp_q, exp_d;
    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic [NUM_OUT-1:0] z_q, z_d;
    logic               mism_q, mism_d;
    logic               ovld_q, ovld_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               capture;
    logic               cmp_mism;

    // compare the live PLA outputs; only used on the capture edge
    pla_vec_cmp #(.W(NUM_OUT)) u_cmp (
        .z        (pla_z),
        .exp      (exp_q),
        .mask     (mask_q),
        .mismatch (cmp_mism)
    );

    // next-state and datapath updates for accept / settle / hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        z_d     = z_q;
        mism_d  = mism_q;
        ovld_d  = ovld_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_vec;
                    exp_d   = in_exp;
                    mask_d  = in_mask;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    z_d     = pla_z;
                    mism_d  = cmp_mism;
                    ovld_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // saturating mismatch counter; clear wins over a same-edge increment
    always_comb begin
        err_d = err_q;
        if (clr_count)
            err_d = '0;
        else if (capture && cmp_mism && (err_q != ERR_MAX))
            err_d = err_q + 1'b1;
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            z_q     <= '0;
            mism_q  <= 1'b0;
            ovld_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            z_q     <= z_d;
            mism_q  <= mism_d;
            ovld_q  <= ovld_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign pla_x        = x_q;
    assign out_valid    = ovld_q;
    assign out_z        = z_q;
    assign out_mismatch = mism_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_pla_vector_driver.sv
// Bench for pla_vector_driver: scoreboard of expected captures pushed at
// acceptance and popped when out_valid rises, plus directed checks.
module tb_pla_vector_driver;

    localparam int NI = 22;
    localparam int NO = 29;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NI-1:0] in_vec = '0;
    logic [NO-1:0] in_exp = '0;
    logic [NO-1:0] in_mask = '0;
    logic [NI-1:0] pla_x;
    logic [NO-1:0] pla_z;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NO-1:0] out_z;
    logic          out_mismatch;
    logic [15:0]   err_count;
    logic          clr_count = 1'b0;
    logic          busy;

    pla_vector_driver #(.NUM_IN(NI), .NUM_OUT(NO), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_exp(in_exp), .in_mask(in_mask), .pla_x(pla_x),
        .pla_z(pla_z), .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_mismatch(out_mismatch), .err_count(err_count),
        .clr_count(clr_count), .busy(busy)
    );

    // external PLA model: identity on the low bits, zero above
    assign pla_z = {7'b0, pla_x};

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [NO-1:0] z;
        logic          m;
        int            acc;
    } sb_t;

    sb_t         q[$];
    int          cyc = 0;
    logic        rst_s = 1'b1;
    logic        clr_s = 1'b0;
    logic        ov_prev = 1'b0;
    logic [NO-1:0] held_z = '0;
    logic        held_m = 1'b0;
    logic [15:0] m_err = '0;
    int          preload_gen = 0;
    int          seen_gen = 0;
    logic        b2b = 1'b0;
    logic        have_last = 1'b0;
    int          last_acc = 0;

    // sample edge-time controls; inputs change #1 after the edge
    always @(posedge clk) begin
        rst_s = rst;
        clr_s = clr_count;
        cyc++;
    end

    // scoreboard monitor and error-counter model, evaluated mid-cycle
    always @(negedge clk) begin
        if (rst_s) begin
            q.delete();
            m_err   = '0;
            ov_prev = 1'b0;
        end else begin
            logic rise;
            sb_t  e;
            logic hit;
            rise = out_valid && !ov_prev;
            hit  = 1'b0;
            if (seen_gen != preload_gen) begin
                m_err    = 16'hFFFE;
                seen_gen = preload_gen;
            end
            if (rise) begin
                if (q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                else begin
                    e   = q.pop_front();
                    hit = e.m;
                    chk("out_z", 32'(out_z), 32'(e.z));
                    chk("out_mismatch", 32'(out_mismatch), 32'(e.m));
                    chk("latency", 32'(cyc - e.acc), 32'(S));
                end
            end
            if (clr_s) m_err = '0;
            else if (rise && hit && m_err != 16'hFFFF) m_err = m_err + 16'd1;
            if (rise) chk("err_count", 32'(err_count), 32'(m_err));
            if (out_valid && ov_prev) begin
                chk("hold_z", 32'(out_z), 32'(held_z));
                chk("hold_m", 32'(out_mismatch), 32'(held_m));
            end
            ov_prev = out_valid;
            held_z  = out_z;
            held_m  = out_mismatch;
            if (!rst && in_valid && in_ready) begin
                e.z   = {7'b0, in_vec};
                e.m   = |((e.z ^ in_exp) & in_mask);
                e.acc = cyc + 1;
                q.push_back(e);
                if (b2b && have_last) chk("b2b_gap", 32'(e.acc - last_acc), 32'd4);
                last_acc  = e.acc;
                have_last = b2b;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 60) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // present one request; returns 1 time unit after the accepting edge
    task automatic send(input logic [NI-1:0] v, input logic [NO-1:0] ex, input logic [NO-1:0] mk);
        wait_idle();
        in_vec = v; in_exp = ex; in_mask = mk; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [NI-1:0] v;
        int n;
        logic rdy;

        // reset and first cycle after release
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pla_x", 32'(pla_x), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);

        // basic match
        send(22'h0000FF, 29'h0000FF, '1);
        chk("busy_settle", 32'(busy), 32'd1);
        wait_idle();
        chk("err_after_match", 32'(err_count), 32'd0);

        // single masked mismatch, then fully masked
        send(22'h3FFFFF, '0, 29'h000001);
        wait_idle();
        chk("err_after_mism", 32'(err_count), 32'd1);
        send(22'h3FFFFF, '0, '0);
        wait_idle();
        chk("err_masked", 32'(err_count), 32'd1);

        // a few random patterns, mask covering the constant-zero upper bits
        for (int i = 0; i < 4; i++) begin
            v = NI'($urandom);
            send(v, {7'($urandom), v ^ NI'(i & 1)}, {$urandom_range(0, 127) == 0 ? 7'h00 : 7'h7F, 22'($urandom)});
        end
        wait_idle();

        // consumer stall with in_valid held high
        out_ready = 1'b0;
        in_vec = 22'h2AAAAA; in_exp = '0; in_mask = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_vec = 22'h155555;
        for (int i = 0; i < S + 10; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_pla_x", 32'(pla_x), 32'h2AAAAA);
        end
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_z", 32'(out_z), 32'h2AAAAA);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        // saturation from a preloaded counter, then clear on a capture edge
        force dut.err_q = 16'hFFFE;
        preload_gen++;
        @(posedge clk); #1;
        release dut.err_q;
        chk("preload", 32'(err_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) send(22'h3FFFFF, '0, '1);
        wait_idle();
        chk("err_sat", 32'(err_count), 32'hFFFF);
        send(22'h3FFFFF, '0, '1);
        @(posedge clk); #1 clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        chk("err_clr_on_capture", 32'(err_count), 32'd0);
        chk("clr_capture_valid", 32'(out_valid), 32'd1);
        wait_idle();

        // reset one cycle into settle discards the request
        send(22'h0ABCDE, '0, '1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_pla_x", 32'(pla_x), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_err", 32'(err_count), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        send(22'h012345, 29'h012345, '1);
        wait_idle();

        // back-to-back requests, consumer always ready
        b2b = 1'b1;
        n = 0;
        in_vec = 22'h000001; in_exp = 29'h000001; in_mask = '1; in_valid = 1'b1;
        for (int t = 0; t < 100 && n < 8; t++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                n++;
                in_vec  = NI'(n * 22'h01111 + 1);
                in_exp  = {7'b0, NI'(n * 22'h01111 + 1)} ^ NO'(n % 3 == 0);
                if (n >= 8) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(n), 32'd8);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        b2b = 1'b0;
        chk("sb_drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
